reg_share_arb: RTL and testbench
================================

REG_SHARE_ARB -- requirements
Module: reg_share_arb

Interface
REQ-001 Parameter: WIDTH, 8, data width of the shared register.
REQ-002 Parameter: NREQ, 4, number of requesters (fixed at 4; other values are not supported).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 req  input  4  per-requester write request, level; bit i belongs to requester i.
REQ-006 wdata  input  4*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH].
REQ-007 gnt  output  4  one-hot grant, registered; all zero when no grant is active.
REQ-008 q  output  WIDTH  shared register contents.
REQ-009 owner  output  2  index of the requester that was granted most recently.
REQ-010 busy  output  1  high when the FSM is not in IDLE.
REQ-011 wr_done  output  1  one-cycle pulse, high in the cycle in which q first shows newly written data.
REQ-012 wr_count  output  8  count of completed writes; wraps from 255 to 0.

Function
REQ-013 The FSM SHALL have three states: IDLE, GRANT and HOLD.
REQ-014 IDLE: on a rising edge with req != 0, the block SHALL latch the round-robin winner into owner and go to GRANT; with req == 0 it SHALL stay in IDLE.
REQ-015 Round-robin: with last = owner, search order SHALL be last+1, last+2, last+3, last (mod 4); the first set req bit wins.
REQ-016 gnt SHALL equal onehot(owner) while in GRANT and SHALL be 0 in IDLE and HOLD; gnt rises exactly 1 cycle after req is sampled in IDLE.
REQ-017 GRANT lasts exactly 1 cycle. On the edge that leaves GRANT, the block SHALL load q with wdata[owner], increment wr_count, set wr_done and go to HOLD.
REQ-018 wr_done SHALL be high for exactly the first HOLD cycle and low otherwise.
REQ-019 If req[owner] drops during GRANT, the write SHALL still complete; a granted write is never cancelled.
REQ-020 HOLD: the block SHALL stay in HOLD while req[owner] is 1 and go to IDLE on the first edge where req[owner] is 0. This limits each requester to one write per req assertion.
REQ-021 Requests from other requesters during GRANT or HOLD SHALL be held off, not lost; they are arbitrated at the next IDLE evaluation.
REQ-022 Minimum spacing between writes SHALL be 3 cycles (IDLE, GRANT, HOLD), giving a minimum of 3 cycles between consecutive wr_done pulses.
REQ-023 q SHALL change only on the GRANT->HOLD edge or on reset.
REQ-024 busy SHALL equal (state != IDLE), registered.

Reset
REQ-025 When rstn is 0, the block SHALL force the following immediately, independent of clk: state=IDLE, q=0, gnt=0, wr_done=0, busy=0, wr_count=0, owner=3.
REQ-026 owner=3 at reset SHALL give requester 0 the highest priority for the first arbitration.
REQ-027 Reset asserted during GRANT or HOLD SHALL abort the cycle: no write occurs and wr_count is not incremented.
REQ-028 While rstn=0, req SHALL be ignored. The first arbitration SHALL occur on the first rising edge with rstn=1.
REQ-029 Reset release timing relative to clk is the integrator's responsibility; no synchronizer is included.

Verification
REQ-030 Reset: hold rstn=0 with req=4'b1111, then pulse rstn low mid-cycle with no clk edge -> q=0, gnt=0, owner=3, wr_count=0 immediately.
REQ-031 Single write: req=4'b0100, wdata[2]=8'hA5, held for 2 cycles and then dropped -> gnt=4'b0100 one cycle after req is sampled; q=8'hA5 and wr_done=1 the next cycle; wr_count=1; busy returns to 0 after req drops.
REQ-032 Round-robin fairness: req=4'b1111 held and each requester drops req after its grant, then reasserts -> grant order is 0,1,2,3,0; wr_count=5.
REQ-033 Hold behaviour: req[1] held high for 10 cycles -> exactly one write, FSM remains in HOLD, gnt=0; req[3] asserted meanwhile is granted only after req[1] drops.
REQ-034 Reset mid-operation: rstn driven low during GRANT with wdata[owner]=8'h3C -> q stays 0, wr_count stays 0, no wr_done pulse.
REQ-035 Counter wrap: 256 completed writes -> wr_count returns to 0 with q holding the last written data.

Source files
------------

// File: rtl/reg_share_arb.sv
// Round-robin arbiter that lets four requesters take turns writing one shared register.
// A granted write always completes; the winner then parks in HOLD until it lowers its request.
module reg_share_arb #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic [1:0]            owner,
    output logic                  busy,
    output logic                  wr_done,
    output logic [7:0]            wr_count,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0]       winner;
    logic [1:0]       cand;
    logic             found;
    logic [NREQ-1:0]  gnt_d;
    logic [1:0]       owner_d;
    logic [WIDTH-1:0] q_d;
    logic             wr_done_d;
    logic             busy_d;
    logic [7:0]       wr_count_d;

    assign state_dbg = state_q;

    // Search starts one past the previous owner and wraps back to it last.
    always_comb begin
        winner = owner;
        cand   = '0;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = owner + k[1:0];
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake: req[i] is a level held by requester i; gnt[i] is high for the single
    // cycle before its wdata slice is written, and the slot is freed only once req[i] drops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = GRANT;
            GRANT:   state_d = HOLD;
            HOLD:    if (!req[owner]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d      = '0;
        owner_d    = owner;
        q_d        = q;
        wr_done_d  = 1'b0;
        wr_count_d = wr_count;
        busy_d     = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d        = winner;
                    gnt_d[winner]  = 1'b1;
                end
            end
            GRANT: begin
                q_d        = wdata[int'(owner)*WIDTH +: WIDTH];
                wr_count_d = wr_count + 8'd1;
                wr_done_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // Owner resets to 3 so requester 0 is first in line after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt      <= '0;
            owner    <= 2'd3;
            q        <= '0;
            wr_done  <= 1'b0;
            busy     <= 1'b0;
            wr_count <= 8'd0;
        end else begin
            gnt      <= gnt_d;
            owner    <= owner_d;
            q        <= q_d;
            wr_done  <= wr_done_d;
            busy     <= busy_d;
            wr_count <= wr_count_d;
        end
    end

endmodule

// File: tb/tb_reg_share_arb.sv
// Directed bench for reg_share_arb: vector table for arbitration order, then hand-written
// sequences for hold-off, asynchronous reset and counter wrap.
module tb_reg_share_arb;

    logic        clk;
    logic        rstn;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [1:0]  owner;
    logic        busy;
    logic        wr_done;
    logic [7:0]  wr_count;
    logic [1:0]  state_dbg;

    int checks;
    int failures;

    reg_share_arb #(.WIDTH(8), .NREQ(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .wdata     (wdata),
        .gnt       (gnt),
        .q         (q),
        .owner     (owner),
        .busy      (busy),
        .wr_done   (wr_done),
        .wr_count  (wr_count),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rstn;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [7:0] q;
        logic [1:0] owner;
        logic       busy;
        logic       wd;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic [7:0] e_q,
                           input logic [1:0] e_owner, input logic e_busy, input logic e_wd,
                           input logic [7:0] e_cnt);
        chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        chk({tag, ".q"}, 32'(q), 32'(e_q));
        chk({tag, ".owner"}, 32'(owner), 32'(e_owner));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".wr_done"}, 32'(wr_done), 32'(e_wd));
        chk({tag, ".wr_count"}, 32'(wr_count), 32'(e_cnt));
    endtask

    logic [7:0] last_d;

    initial begin
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        req      = 4'b1111;
        // requester 3..0 data
        wdata    = 32'hD3A5710F;

        vecs[0]  = '{1'b0, 4'b1111, 4'b0000, 8'h00, 2'd3, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 4'b1111, 4'b0001, 8'h00, 2'd0, 1'b1, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 4'b1111, 4'b0000, 8'h0F, 2'd0, 1'b1, 1'b1, 8'd1};
        vecs[3]  = '{1'b1, 4'b1110, 4'b0000, 8'h0F, 2'd0, 1'b0, 1'b0, 8'd1};
        vecs[4]  = '{1'b1, 4'b1111, 4'b0010, 8'h0F, 2'd1, 1'b1, 1'b0, 8'd1};
        vecs[5]  = '{1'b1, 4'b1111, 4'b0000, 8'h71, 2'd1, 1'b1, 1'b1, 8'd2};
        vecs[6]  = '{1'b1, 4'b1101, 4'b0000, 8'h71, 2'd1, 1'b0, 1'b0, 8'd2};
        vecs[7]  = '{1'b1, 4'b1111, 4'b0100, 8'h71, 2'd2, 1'b1, 1'b0, 8'd2};
        vecs[8]  = '{1'b1, 4'b1111, 4'b0000, 8'hA5, 2'd2, 1'b1, 1'b1, 8'd3};
        vecs[9]  = '{1'b1, 4'b1011, 4'b0000, 8'hA5, 2'd2, 1'b0, 1'b0, 8'd3};
        vecs[10] = '{1'b1, 4'b1111, 4'b1000, 8'hA5, 2'd3, 1'b1, 1'b0, 8'd3};
        vecs[11] = '{1'b1, 4'b1111, 4'b0000, 8'hD3, 2'd3, 1'b1, 1'b1, 8'd4};
        vecs[12] = '{1'b1, 4'b0111, 4'b0000, 8'hD3, 2'd3, 1'b0, 1'b0, 8'd4};
        vecs[13] = '{1'b1, 4'b1111, 4'b0001, 8'hD3, 2'd0, 1'b1, 1'b0, 8'd4};
        vecs[14] = '{1'b1, 4'b1111, 4'b0000, 8'h0F, 2'd0, 1'b1, 1'b1, 8'd5};
        vecs[15] = '{1'b1, 4'b1110, 4'b0000, 8'h0F, 2'd0, 1'b0, 1'b0, 8'd5};
        vecs[16] = '{1'b1, 4'b0100, 4'b0100, 8'h0F, 2'd2, 1'b1, 1'b0, 8'd5};
        vecs[17] = '{1'b1, 4'b0100, 4'b0000, 8'hA5, 2'd2, 1'b1, 1'b1, 8'd6};
        vecs[18] = '{1'b1, 4'b0000, 4'b0000, 8'hA5, 2'd2, 1'b0, 1'b0, 8'd6};
        vecs[19] = '{1'b1, 4'b0000, 4'b0000, 8'hA5, 2'd2, 1'b0, 1'b0, 8'd6};

        // reset held with requests pending
        step();
        step();
        chk_all("reset_hold", 4'b0000, 8'h00, 2'd3, 1'b0, 1'b0, 8'd0);

        // fairness order 0,1,2,3,0 followed by a single write from requester 2
        for (int i = 0; i < 20; i++) begin
            rstn = vecs[i].rstn;
            req  = vecs[i].req;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].q, vecs[i].owner,
                    vecs[i].busy, vecs[i].wd, vecs[i].cnt);
        end

        // requester 1 holds for 10 cycles while requester 3 waits
        req = 4'b0010;
        step();
        chk_all("hold_grant1", 4'b0010, 8'hA5, 2'd1, 1'b1, 1'b0, 8'd6);
        step();
        chk_all("hold_write1", 4'b0000, 8'h71, 2'd1, 1'b1, 1'b1, 8'd7);
        req = 4'b1010;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_all($sformatf("hold_wait%0d", i), 4'b0000, 8'h71, 2'd1, 1'b1, 1'b0, 8'd7);
            chk($sformatf("hold_state%0d", i), 32'(state_dbg), 32'd2);
        end
        req = 4'b1000;
        step();
        chk_all("hold_release", 4'b0000, 8'h71, 2'd1, 1'b0, 1'b0, 8'd7);
        step();
        chk_all("hold_grant3", 4'b1000, 8'h71, 2'd3, 1'b1, 1'b0, 8'd7);
        step();
        chk_all("hold_write3", 4'b0000, 8'hD3, 2'd3, 1'b1, 1'b1, 8'd8);
        req = 4'b0000;
        step();
        chk_all("hold_idle", 4'b0000, 8'hD3, 2'd3, 1'b0, 1'b0, 8'd8);

        // asynchronous reset between clock edges
        req = 4'b1111;
        step();
        chk_all("async_pre", 4'b0001, 8'hD3, 2'd0, 1'b1, 1'b0, 8'd8);
        #3;
        rstn = 1'b0;
        #1;
        chk_all("async_now", 4'b0000, 8'h00, 2'd3, 1'b0, 1'b0, 8'd0);
        step();
        chk_all("async_held", 4'b0000, 8'h00, 2'd3, 1'b0, 1'b0, 8'd0);

        // reset during GRANT aborts the write
        rstn  = 1'b1;
        req   = 4'b0001;
        wdata = 32'hD3A5713C;
        step();
        chk_all("abort_grant", 4'b0001, 8'h00, 2'd0, 1'b1, 1'b0, 8'd0);
        #3;
        rstn = 1'b0;
        step();
        chk_all("abort_edge", 4'b0000, 8'h00, 2'd3, 1'b0, 1'b0, 8'd0);
        rstn = 1'b1;
        req  = 4'b0000;
        step();
        chk_all("abort_after", 4'b0000, 8'h00, 2'd3, 1'b0, 1'b0, 8'd0);

        // 256 writes wrap the counter
        last_d = 8'h00;
        for (int i = 0; i < 256; i++) begin
            last_d = 8'(i) ^ 8'h5A;
            wdata  = {24'hD3A571, last_d};
            req    = 4'b0001;
            step();
            step();
            chk($sformatf("wrap_q%0d", i), 32'(q), 32'(last_d));
            chk($sformatf("wrap_cnt%0d", i), 32'(wr_count), 32'((i + 1) % 256));
            req = 4'b0000;
            step();
        end
        chk("wrap_final_cnt", 32'(wr_count), 32'd0);
        chk("wrap_final_q", 32'(q), 32'h000000A5);
        chk("wrap_final_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
